// File: rtl/timer_sched_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the timer scheduler.
package timer_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 16;
    localparam int RR_MAX   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // First set request searching upward from last+1, wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        last,
                                         input int                n);
        rr_pick_t r;
        int       j;
        r.valid = 1'b0;
        r.idx   = 3'd0;
        for (int k = 1; k <= RR_MAX; k++) begin
            j = (int'(last) + k) % n;
            if (k <= n && !r.valid && req[j[2:0]]) begin
                r.valid = 1'b1;
                r.idx   = j[2:0];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_sched_load_down_counter.sv
// Loadable down-counter that saturates at zero; shared by all requesters.
module load_down_counter
    import timer_sched_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    logic [CW-1:0] count_q;

    // Counter register: load has priority, decrement stops at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {CW{1'b0}};
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != {CW{1'b0}})) begin
            count_q <= count_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_q <= count_q;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == {CW{1'b0}});

endmodule

// File: rtl/timer_sched.sv
// Round-robin scheduler sharing one down-counter among NREQ timer requesters,
// with per-requester sticky completion flags and a maskable interrupt.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               abort,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] req_delay,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [IW-1:0]      cur_id,
    output logic [CW-1:0]      count,
    input  logic [NREQ-1:0]    irq_mask,
    input  logic [NREQ-1:0]    irq_clr,
    output logic [NREQ-1:0]    irq_pend,
    output logic               irq
);

    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              busy_q, busy_d;
    logic [IW-1:0]     cur_id_q, cur_id_d;
    logic [IW-1:0]     last_q, last_d;
    logic [NREQ-1:0]   pend_q, pend_d;
    logic              irq_q, irq_d;
    logic              load_s, dec_s, zero_s;
    logic [CW-1:0]     cnt_s;
    rr_pick_t          pick_s;

    assign pick_s = rr_pick(RR_MAX'(req), 3'(last_q), NREQ);

    load_down_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_val (req_delay[pick_s.idx*CW +: CW]),
        .dec      (dec_s),
        .count    (cnt_s),
        .zero     (zero_s)
    );

    // Next-state and pulse generation; abort beats completion on the zero cycle.
    always_comb begin
        state_d  = state_q;
        grant_d  = {NREQ{1'b0}};
        done_d   = {NREQ{1'b0}};
        busy_d   = busy_q;
        cur_id_d = cur_id_q;
        last_d   = last_q;
        load_s   = 1'b0;
        dec_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && pick_s.valid) begin
                    grant_d  = ONE_HOT0 << pick_s.idx;
                    cur_id_d = IW'(pick_s.idx);
                    last_d   = IW'(pick_s.idx);
                    load_s   = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = COUNT;
                end else begin
                    state_d  = IDLE;
                end
            end
            COUNT: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (zero_s) begin
                    done_d  = ONE_HOT0 << cur_id_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    dec_s   = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
        pend_d = (pend_q & ~irq_clr) | done_d;
        irq_d  = |(pend_q & irq_mask);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= {NREQ{1'b0}};
            done_q   <= {NREQ{1'b0}};
            busy_q   <= 1'b0;
            cur_id_q <= {IW{1'b0}};
            last_q   <= IW'(NREQ - 1);
            pend_q   <= {NREQ{1'b0}};
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            cur_id_q <= cur_id_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign cur_id   = cur_id_q;
    assign count    = cnt_s;
    assign irq_pend = pend_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_timer_sched.sv
// Scoreboard bench for timer_sched: expected grant/done pulses (with edge number)
// are queued by the stimulus and retired by an independent monitor.
module tb_timer_sched;

    localparam int NREQ = 4;
    localparam int CW   = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic               abort = 1'b0;
    logic [NREQ-1:0]    req = 4'b0000;
    logic [NREQ*CW-1:0] req_delay = 64'd0;
    logic [NREQ-1:0]    grant, done, irq_pend;
    logic               busy, irq;
    logic [1:0]         cur_id;
    logic [CW-1:0]      count;
    logic [NREQ-1:0]    irq_mask = 4'b0000;
    logic [NREQ-1:0]    irq_clr = 4'b0000;

    timer_sched #(.NREQ(NREQ), .CW(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .abort(abort),
        .req(req), .req_delay(req_delay), .grant(grant), .done(done),
        .busy(busy), .cur_id(cur_id), .count(count), .irq_mask(irq_mask),
        .irq_clr(irq_clr), .irq_pend(irq_pend), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        logic [3:0] vec;
        int         cyc;
    } evt_t;

    evt_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void retire(bit is_done, logic [3:0] vec);
        evt_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got %b at cycle %0d, nothing expected",
                     is_done ? "done" : "grant", vec, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.is_done != is_done || e.vec !== vec || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got %s %b @%0d expected %s %b @%0d",
                         is_done ? "done" : "grant", vec, cyc,
                         e.is_done ? "done" : "grant", e.vec, e.cyc);
            end
        end
    endfunction

    // Monitor: retire queued expectations whenever the DUT pulses grant or done.
    always @(negedge clk) begin
        if (grant !== 4'b0000) retire(1'b0, grant);
        if (done !== 4'b0000) retire(1'b1, done);
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(bit d, logic [3:0] v, int c);
        evt_t e;
        e.is_done = d;
        e.vec = v;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic set_delay(int i, logic [CW-1:0] d);
        req_delay[i*CW +: CW] = d;
    endtask

    // Raise one request; returns at the negedge where the grant is visible, req dropped.
    task automatic issue(int idx, logic [CW-1:0] d, bit expect_done);
        logic [3:0] v;
        v = 4'b0001 << idx;
        set_delay(idx, d);
        req = req | v;
        push(1'b0, v, cyc + 1);
        if (expect_done) push(1'b1, v, cyc + 2 + int'(d));
        step(1);
        req = req & ~v;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cur_id"}, 32'(cur_id), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_pend"}, 32'(irq_pend), 32'd0);
        chk({tag, "_irq"}, 32'(irq), 32'd0);
    endtask

    initial begin
        int n;
        step(1);
        chk_reset_vals("por");
        reset = 1'b0;
        enable = 1'b1;
        step(1);

        // Single request, delay 5, masked-in irq
        irq_mask = 4'b0100;
        issue(2, 16'd5, 1'b1);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_cur_id", 32'(cur_id), 32'd2);
        chk("single_count5", 32'(count), 32'd5);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk("single_countdown", 32'(count), 32'(5 - k));
        end
        step(1);
        chk("single_pend", 32'(irq_pend), 32'b0100);
        chk("single_irq_lag", 32'(irq), 32'd0);
        chk("single_idle", 32'(busy), 32'd0);
        step(1);
        chk("single_irq", 32'(irq), 32'd1);
        irq_clr = 4'b0100;
        step(1);
        irq_clr = 4'b0000;
        chk("clr_pend", 32'(irq_pend), 32'd0);
        step(1);
        chk("clr_irq", 32'(irq), 32'd0);

        // Round-robin after a fresh reset: order 0,1,2,3,0 every 3 cycles
        reset = 1'b1;
        irq_mask = 4'b0000;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_delay(i, 16'd1);
        n = cyc;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push(1'b0, 4'b0001 << (k % 4), n + 1 + 3 * k);
            push(1'b1, 4'b0001 << (k % 4), n + 3 + 3 * k);
        end
        step(13);
        req = 4'b0000;
        step(3);
        chk("rr_pend", 32'(irq_pend), 32'b1111);

        // Delay 0: done one cycle after grant (last grant 0, so requester 1 wins)
        issue(1, 16'd0, 1'b1);
        step(2);

        // Maximum delay: no wrap at zero
        issue(3, 16'hFFFF, 1'b1);
        chk("max_count", 32'(count), 32'hFFFF);
        step(65535);
        chk("max_zero", 32'(count), 32'd0);
        chk("max_busy", 32'(busy), 32'd1);
        step(1);
        chk("max_idle", 32'(busy), 32'd0);
        step(1);
        chk("max_nowrap", 32'(count), 32'd0);
        irq_clr = 4'b1111;
        step(1);
        irq_clr = 4'b0000;
        chk("clr_all", 32'(irq_pend), 32'd0);

        // Abort at count 3, then immediate regrant
        issue(2, 16'd10, 1'b0);
        step(7);
        chk("abort_pre", 32'(count), 32'd3);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hold", 32'(count), 32'd3);
        issue(0, 16'd2, 1'b1);
        step(4);
        chk("abort_pend", 32'(irq_pend), 32'b0001);

        // Abort coinciding with count==0 wins over done
        issue(1, 16'd2, 1'b0);
        step(2);
        chk("abz_zero", 32'(count), 32'd0);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abz_busy", 32'(busy), 32'd0);
        chk("abz_pend", 32'(irq_pend), 32'b0001);
        step(2);

        // irq_clr concurrent with done: set wins, then clears
        irq_mask = 4'b0010;
        issue(1, 16'd0, 1'b1);
        irq_clr = 4'b0010;
        step(1);
        chk("clr_setwins", 32'(irq_pend), 32'b0011);
        step(1);
        irq_clr = 4'b0000;
        chk("clr_next", 32'(irq_pend), 32'b0001);
        chk("clr_irq_hi", 32'(irq), 32'd1);
        step(1);
        chk("clr_irq_lo", 32'(irq), 32'd0);
        chk("mask_keeps", 32'(irq_pend), 32'b0001);

        // enable dropped mid-count: finishes, no new grants
        issue(2, 16'd3, 1'b1);
        enable = 1'b0;
        req = 4'b1011;
        step(4);
        chk("en_done_idle", 32'(busy), 32'd0);
        step(6);
        chk("en_no_grant", 32'(busy), 32'd0);
        req = 4'b0000;
        enable = 1'b1;
        step(1);

        // Reset mid-count, then requester 0 wins first
        issue(0, 16'd20, 1'b0);
        step(3);
        chk("rst_pre", 32'(count), 32'd17);
        reset = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_delay(i, 16'd1);
        req = 4'b1011;
        push(1'b0, 4'b0001, cyc + 1);
        push(1'b1, 4'b0001, cyc + 3);
        step(1);
        req = 4'b0000;
        step(4);

        chk("leftover_events", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
